// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron datapath and its rate monitor.
package lif_pkg;

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned WIN_BASE_LOG2 = 4;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned WIN_W         = WIN_BASE_LOG2 + (1 << SEL_W) - 1;

  localparam logic [CNT_W-1:0] RATE_MAX = {CNT_W{1'b1}};

  // Window length in cycles; one bit wider than the window counter so the longest window fits.
  function automatic logic [WIN_W:0] win_len(input logic [SEL_W-1:0] sel);
    return (WIN_W + 1)'(1) << (WIN_BASE_LOG2 + 32'(sel));
  endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector on a level signal; the previous sample only advances while enabled.
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic level_i,
  output logic rise_c
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else if (ena) begin
      prev_q <= level_i;
    end
  end

  assign rise_c = level_i & ~prev_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts spike rising edges over a programmable window and latches the per-window rate.
module spike_rate_monitor
  import lif_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [SEL_W-1:0] window_sel,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_sat,
  output logic             rate_valid,
  output logic             win_active
);

  logic             rise_c;
  logic             active_q, active_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_sat_q, rate_sat_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             sat_inc_c;
  logic             last_c;

  spike_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .level_i (spike_in),
    .rise_c  (rise_c)
  );

  // Window bookkeeping; an edge on the closing cycle is folded into the reported count.
  always_comb begin
    active_d   = active_q;
    sel_d      = sel_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    rate_d     = rate_q;
    rate_sat_d = rate_sat_q;
    valid_d    = 1'b0;
    cnt_inc_c  = cnt_q;
    sat_inc_c  = sat_q;
    last_c     = (win_q == WIN_W'(win_len(sel_q) - (WIN_W + 1)'(1)));

    if (rise_c) begin
      if (cnt_q == RATE_MAX) begin
        sat_inc_c = 1'b1;
      end else begin
        cnt_inc_c = cnt_q + CNT_W'(1);
      end
    end

    if (ena) begin
      if (!active_q) begin
        active_d = 1'b1;
        sel_d    = window_sel;
      end
      if (last_c) begin
        rate_d     = cnt_inc_c;
        rate_sat_d = sat_inc_c;
        valid_d    = 1'b1;
        win_d      = '0;
        cnt_d      = '0;
        sat_d      = 1'b0;
        sel_d      = window_sel;
      end else begin
        win_d = win_q + WIN_W'(1);
        cnt_d = cnt_inc_c;
        sat_d = sat_inc_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      sel_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      rate_q     <= '0;
      rate_sat_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      active_q   <= active_d;
      sel_q      <= sel_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      rate_q     <= rate_d;
      rate_sat_q <= rate_sat_d;
      valid_q    <= valid_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_sat   = rate_sat_q;
  assign rate_valid = valid_q;
  assign win_active = active_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor: directed tables, corner sequences, random vs model.
module tb_spike_rate_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       spike_in;
  logic [2:0] window_sel;
  logic [7:0] rate_out;
  logic       rate_sat;
  logic       rate_valid;
  logic       win_active;

  spike_rate_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .window_sel (window_sel),
    .rate_out   (rate_out),
    .rate_sat   (rate_sat),
    .rate_valid (rate_valid),
    .win_active (win_active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: unbounded event count per window, clipped only when reported.
  bit m_active;
  int m_sel;
  int m_pos;
  int m_cnt;
  bit m_prev;
  int e_rate;
  bit e_sat;
  bit e_valid;

  typedef struct {
    int period;
    int phase;
    int exp_rate;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_sel = 0; m_pos = 0; m_cnt = 0; m_prev = 0;
    e_rate = 0; e_sat = 0; e_valid = 0;
  endtask

  task automatic model_step(input bit s, input bit e, input int ws);
    e_valid = 0;
    if (e) begin
      if (!m_active) begin
        m_active = 1;
        m_sel    = ws;
      end
      if (s && !m_prev) m_cnt++;
      m_prev = s;
      if (m_pos == (1 << (4 + m_sel)) - 1) begin
        e_rate  = (m_cnt > 255) ? 255 : m_cnt;
        e_sat   = (m_cnt > 255);
        e_valid = 1;
        m_cnt   = 0;
        m_pos   = 0;
        m_sel   = ws;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic tick(input bit s, input bit e, input int ws);
    spike_in   = s;
    ena        = e;
    window_sel = 3'(ws);
    model_step(s, e, ws);
    @(posedge clk);
    #1;
    chk("model_rate_out",   int'(rate_out),   e_rate);
    chk("model_rate_sat",   int'(rate_sat),   int'(e_sat));
    chk("model_rate_valid", int'(rate_valid), int'(e_valid));
    chk("model_win_active", int'(win_active), int'(m_active));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; window_sel = 3'd0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_rate_out",   int'(rate_out),   0);
    chk("reset_rate_sat",   int'(rate_sat),   0);
    chk("reset_rate_valid", int'(rate_valid), 0);
    chk("reset_win_active", int'(win_active), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int mode;
    bit s;

    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; window_sel = 3'd0;
    #1;

    tbl[0] = '{period: 4,  phase: 0,  exp_rate: 4};
    tbl[1] = '{period: 4,  phase: 1,  exp_rate: 4};
    tbl[2] = '{period: 2,  phase: 1,  exp_rate: 8};
    tbl[3] = '{period: 16, phase: 15, exp_rate: 1};
    tbl[4] = '{period: 8,  phase: 7,  exp_rate: 2};
    tbl[5] = '{period: 16, phase: 0,  exp_rate: 1};

    // Periodic single-cycle spikes, two windows of 16 each.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      for (int i = 0; i < 32; i++) begin
        tick((i >= tbl[k].phase) && ((i - tbl[k].phase) % tbl[k].period == 0), 1'b1, 0);
        if (i == 15 || i == 31) begin
          chk("tbl_valid", int'(rate_valid), 1);
          chk("tbl_rate",  int'(rate_out),   tbl[k].exp_rate);
          chk("tbl_sat",   int'(rate_sat),   0);
        end else if (i == 14 || i == 16) begin
          chk("tbl_novalid", int'(rate_valid), 0);
        end
      end
    end

    // Level held high across windows counts once.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      tick(i >= 2 && i < 42, 1'b1, 0);
      if (i == 15) chk("held_w0", int'(rate_out), 1);
      if (i == 31) chk("held_w1", int'(rate_out), 0);
      if (i == 47) chk("held_w2", int'(rate_out), 0);
    end

    // Closing-cycle edge belongs to the closing window.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick(i == 15, 1'b1, 0);
      if (i == 15) chk("close_incl_w0", int'(rate_out), 1);
      if (i == 31) chk("close_incl_w1", int'(rate_out), 0);
    end

    // Saturation in a 512-cycle window, then a clean idle window.
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      tick((i < 512) && (i % 2 == 0), 1'b1, 5);
      if (i == 511) begin
        chk("sat_valid", int'(rate_valid), 1);
        chk("sat_rate",  int'(rate_out),   255);
        chk("sat_flag",  int'(rate_sat),   1);
      end
      if (i == 1023) begin
        chk("sat_idle_rate", int'(rate_out), 0);
        chk("sat_idle_flag", int'(rate_sat), 0);
      end
    end

    // Mid-window select change applies to the next window.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, 1'b1, (i < 5) ? 0 : 1);
      if (rate_valid) pulses++;
      if (i == 15) chk("sel_close16", int'(rate_valid), 1);
      if (i == 47) chk("sel_close48", int'(rate_valid), 1);
    end
    chk("sel_pulses", pulses, 2);

    // Enable gap with a toggling input, then three spikes after resume.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 0);
    for (int j = 0; j < 10; j++) begin
      tick(j % 2 == 0, 1'b0, 0);
      if (rate_valid) pulses++;
    end
    for (int p = 4; p < 16; p++) begin
      tick(p == 5 || p == 8 || p == 11, 1'b1, 0);
      if (rate_valid) pulses++;
    end
    chk("ena_gap_valid", int'(rate_valid), 1);
    chk("ena_gap_rate",  int'(rate_out),   3);
    chk("ena_gap_pulses", pulses, 1);

    // Reset mid-window discards the partial count.
    do_reset();
    for (int i = 0; i < 8; i++) tick(i == 1 || i == 4, 1'b1, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_valid",  int'(rate_valid), 0);
    chk("midrst_rate",   int'(rate_out),   0);
    chk("midrst_active", int'(win_active), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick(i == 3, 1'b1, 0);
      if (rate_valid) pulses++;
      if (i == 14) chk("midrst_rate_hold", int'(rate_out), 0);
    end
    chk("midrst_close_rate", int'(rate_out), 1);
    chk("midrst_pulses", pulses, 1);

    // Randomized run against the model, alternating sparse and dense spike phases.
    do_reset();
    mode = 0;
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) mode = $urandom_range(0, 1);
      if (i == 1500) do_reset();
      if (mode == 1) s = ~s;
      else s = ($urandom_range(0, 3) == 0);
      tick(s, $urandom_range(0, 9) != 0, $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
